// File: rtl/score_bcd_counter.sv
// Breakout score/lives keeper: packed-BCD score with saturation, lives counter,
// game-over sequencing and a high-score register updated at the end of each game.
module score_bcd_counter #(
  parameter int NUM_DIGITS = 4,
  parameter int LIVES_INIT = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    hit,
  input  logic [3:0]              hit_value,
  input  logic                    life_lost,
  input  logic                    restart,
  output logic [4*NUM_DIGITS-1:0] score,
  output logic [4*NUM_DIGITS-1:0] hi_score,
  output logic [3:0]              lives,
  output logic                    game_over,
  output logic                    new_record
);

  localparam logic [3:0] LIVES_RST = 4'(LIVES_INIT);
  localparam logic [4*NUM_DIGITS-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

  typedef enum logic [1:0] {PLAY, CMP, OVER} state_t;

  state_t                  state, state_next;
  logic [4*NUM_DIGITS-1:0] score_next, hi_next, score_sum;
  logic [3:0]              lives_next;
  logic                    rec_next;
  logic [3:0]              v;
  logic [4:0]              cin, dsum;

  // Decimal ripple add of the clamped hit value; a carry out of the top digit saturates.
  always_comb begin
    v         = (hit_value > 4'd9) ? 4'd9 : hit_value;
    cin       = {1'b0, v};
    dsum      = '0;
    score_sum = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      dsum = {1'b0, score[4*i +: 4]} + cin;
      if (dsum > 5'd9) begin
        score_sum[4*i +: 4] = 4'(dsum - 5'd10);
        cin = 5'd1;
      end else begin
        score_sum[4*i +: 4] = dsum[3:0];
        cin = 5'd0;
      end
    end
    if (cin[0])
      score_sum = ALL_NINES;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= PLAY;
      score      <= '0;
      hi_score   <= '0;
      lives      <= LIVES_RST;
      new_record <= 1'b0;
    end else begin
      state      <= state_next;
      score      <= score_next;
      hi_score   <= hi_next;
      lives      <= lives_next;
      new_record <= rec_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      PLAY:    if (!restart && life_lost && lives == 4'd1) state_next = CMP;
      CMP:     state_next = OVER;
      OVER:    if (restart) state_next = PLAY;
      default: state_next = PLAY;
    endcase
  end

  always_comb begin
    score_next = score;
    hi_next    = hi_score;
    lives_next = lives;
    rec_next   = 1'b0;
    case (state)
      PLAY: begin
        if (restart) begin
          score_next = '0;
          lives_next = LIVES_RST;
        end else begin
          if (hit)
            score_next = score_sum;
          if (life_lost && lives != 4'd0)
            lives_next = lives - 4'd1;
        end
      end
      CMP: begin
        // Packed BCD orders the same as binary, so a plain unsigned compare is digit-wise.
        if (score > hi_score) begin
          hi_next  = score;
          rec_next = 1'b1;
        end
      end
      OVER: begin
        if (restart) begin
          score_next = '0;
          lives_next = LIVES_RST;
        end
      end
      default: ;
    endcase
  end

  assign game_over = (state != PLAY);

endmodule

// File: tb/tb_score_bcd_counter.sv
// Directed, table-driven bench for score_bcd_counter plus a saturation sequence.
module tb_score_bcd_counter;

  logic        clk = 1'b0;
  logic        reset, hit, life_lost, restart;
  logic [3:0]  hit_value;
  logic [15:0] score, hi_score;
  logic [3:0]  lives;
  logic        game_over, new_record;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        rst, hit;
    logic [3:0]  val;
    logic        ll, rs;
    logic [15:0] s, h;
    logic [3:0]  lv;
    logic        go, rec;
  } vec_t;

  vec_t vecs[$];

  score_bcd_counter #(.NUM_DIGITS(4), .LIVES_INIT(3)) dut (
    .clk(clk), .reset(reset), .hit(hit), .hit_value(hit_value),
    .life_lost(life_lost), .restart(restart), .score(score),
    .hi_score(hi_score), .lives(lives), .game_over(game_over),
    .new_record(new_record)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    int          m;
    r = '0;
    m = n;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  task automatic add(input logic rst, input logic h, input int val, input logic ll,
                     input logic rs, input int s_dec, input int h_dec, input int lv,
                     input logic go, input logic rec);
    vec_t t;
    t.rst = rst; t.hit = h; t.val = 4'(val); t.ll = ll; t.rs = rs;
    t.s = to_bcd(s_dec); t.h = to_bcd(h_dec); t.lv = 4'(lv); t.go = go; t.rec = rec;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive_step(input logic rst, input logic h, input logic [3:0] val,
                            input logic ll, input logic rs);
    reset = rst; hit = h; hit_value = val; life_lost = ll; restart = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int model;
    reset = 1'b1; hit = 1'b0; hit_value = '0; life_lost = 1'b0; restart = 1'b0;

    // rst hit val ll rs | score hi lives go rec
    add(1, 0, 0,  0, 0,   0,   0, 3, 0, 0);
    add(0, 1, 7,  0, 0,   7,   0, 3, 0, 0);
    add(0, 1, 7,  0, 0,  14,   0, 3, 0, 0);
    add(0, 1, 7,  0, 0,  21,   0, 3, 0, 0);
    add(0, 1, 15, 0, 0,  30,   0, 3, 0, 0);
    add(0, 1, 0,  0, 0,  30,   0, 3, 0, 0);
    add(0, 0, 0,  1, 0,  30,   0, 2, 0, 0);
    add(0, 1, 5,  1, 1,   0,   0, 3, 0, 0);
    add(0, 1, 15, 0, 0,   9,   0, 3, 0, 0);
    for (int k = 1; k <= 12; k++)
      add(0, 1, 9, 0, 0, 9 + 9*k, 0, 3, 0, 0);
    add(0, 1, 6,  0, 0, 123,   0, 3, 0, 0);
    add(0, 0, 0,  1, 0, 123,   0, 2, 0, 0);
    add(0, 0, 0,  1, 0, 123,   0, 1, 0, 0);
    add(0, 1, 5,  1, 0, 128,   0, 0, 1, 0);
    add(0, 0, 0,  0, 0, 128, 128, 0, 1, 1);
    add(0, 0, 0,  0, 0, 128, 128, 0, 1, 0);
    add(0, 1, 9,  1, 0, 128, 128, 0, 1, 0);
    add(0, 0, 0,  0, 1,   0, 128, 3, 0, 0);
    for (int k = 1; k <= 5; k++)
      add(0, 1, 9, 0, 0, 9*k, 128, 3, 0, 0);
    add(0, 1, 5,  0, 0,  50, 128, 3, 0, 0);
    add(0, 0, 0,  1, 0,  50, 128, 2, 0, 0);
    add(0, 0, 0,  1, 0,  50, 128, 1, 0, 0);
    add(0, 0, 0,  1, 0,  50, 128, 0, 1, 0);
    add(0, 0, 0,  0, 0,  50, 128, 0, 1, 0);
    add(0, 0, 0,  0, 0,  50, 128, 0, 1, 0);
    add(0, 0, 0,  0, 1,   0, 128, 3, 0, 0);
    add(0, 0, 0,  1, 0,   0, 128, 2, 0, 0);
    add(0, 0, 0,  1, 0,   0, 128, 1, 0, 0);
    add(0, 0, 0,  1, 0,   0, 128, 0, 1, 0);
    add(0, 0, 0,  0, 1,   0, 128, 0, 1, 0);
    add(0, 0, 0,  0, 0,   0, 128, 0, 1, 0);
    add(0, 0, 0,  0, 1,   0, 128, 3, 0, 0);
    add(0, 1, 9,  0, 0,   9, 128, 3, 0, 0);
    add(0, 0, 0,  1, 0,   9, 128, 2, 0, 0);
    add(0, 0, 0,  1, 0,   9, 128, 1, 0, 0);
    add(0, 0, 0,  1, 0,   9, 128, 0, 1, 0);
    add(0, 0, 0,  0, 0,   9, 128, 0, 1, 0);
    add(1, 0, 0,  0, 0,   0,   0, 3, 0, 0);
    add(0, 1, 3,  0, 0,   3,   0, 3, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive_step(vecs[i].rst, vecs[i].hit, vecs[i].val, vecs[i].ll, vecs[i].rs);
      chk("score",      i, score,             vecs[i].s);
      chk("hi_score",   i, hi_score,          vecs[i].h);
      chk("lives",      i, {12'b0, lives},    {12'b0, vecs[i].lv});
      chk("game_over",  i, {15'b0, game_over}, {15'b0, vecs[i].go});
      chk("new_record", i, {15'b0, new_record}, {15'b0, vecs[i].rec});
    end

    // Saturation: climb to 9995 with a decimal model, then overflow with 9 and 12.
    drive_step(1, 0, 4'd0, 0, 0);
    model = 0;
    for (int k = 0; k < 1110; k++) begin
      drive_step(0, 1, 4'd9, 0, 0);
      model += 9;
      chk("climb", k, score, to_bcd(model));
    end
    drive_step(0, 1, 4'd5, 0, 0);
    chk("sat_9995", 0, score, to_bcd(9995));
    drive_step(0, 1, 4'd9, 0, 0);
    chk("sat_9999", 0, score, 16'h9999);
    drive_step(0, 1, 4'd12, 0, 0);
    chk("sat_hold", 0, score, 16'h9999);
    chk("sat_lives", 0, {12'b0, lives}, 16'd3);
    chk("sat_go", 0, {15'b0, game_over}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
